// File: rtl/pipelined_cla_addsub_pkg.sv
// rtl/pipelined_cla_addsub_pkg.sv - op encodings and default geometry shared across the tile
package pipelined_cla_addsub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_ADC = 2'b01,
      OP_SUB = 2'b10,
      OP_SBB = 2'b11
   } op_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_GROUP = 4;

   // Subtract ops feed the inverted B operand into the adder.
   function automatic logic op_is_sub(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// rtl/pipelined_cla_addsub_cla_group.sv - combinational GROUP-bit carry-lookahead group
module cla_group
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int GROUP = DEF_GROUP
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b_eff,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout
);

   logic [GROUP-1:0] w_p;
   logic [GROUP-1:0] w_g;
   logic [GROUP:0]   w_c;
   logic             w_t;
   logic             w_acc;

   assign w_p = a ^ b_eff;
   assign w_g = a & b_eff;

   // Each carry is the flattened sum-of-products, not a ripple chain.
   always_comb begin
      w_c    = '0;
      w_t    = 1'b0;
      w_acc  = 1'b0;
      w_c[0] = cin;
      for (int i = 0; i < GROUP; i++) begin
         w_t = cin;
         for (int j = 0; j <= i; j++) begin
            w_t = w_t & w_p[j];
         end
         w_acc = w_t;
         for (int j = 0; j <= i; j++) begin
            w_t = w_g[j];
            for (int k = j + 1; k <= i; k++) begin
               w_t = w_t & w_p[k];
            end
            w_acc = w_acc | w_t;
         end
         w_c[i+1] = w_acc;
      end
   end

   assign sum  = w_p ^ w_c[GROUP-1:0];
   assign cout = w_c[GROUP];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined CLA adder/subtractor, one lookahead group per stage
module pipelined_cla_addsub
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int GROUP = DEF_GROUP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / GROUP;

   op_e              w_op;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_c0;
   logic             w_stall;
   logic             w_accept;
   logic             r_out_v;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   assign w_op = op_e'(op);

   always_comb begin
      w_c0    = 1'b0;
      w_b_eff = op_is_sub(w_op) ? ~b : b;
      case (w_op)
         OP_ADC:  w_c0 = cin;
         OP_SUB:  w_c0 = 1'b1;
         OP_SBB:  w_c0 = ~cin;
         default: w_c0 = 1'b0;
      endcase
   end

   assign w_stall  = ~ena | (r_out_v & ~out_ready);
   assign w_accept = in_valid & ~w_stall;
   assign in_ready = ~w_stall;

   genvar s;
   for (s = 0; s < STAGES; s++) begin : g_stg
      localparam int LO  = s * GROUP;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]      w_a;
      logic [REM-1:0]      w_b;
      logic                w_cin;
      logic                w_v;
      logic [GROUP-1:0]    w_gsum;
      logic                w_gcout;
      logic [LO+GROUP-1:0] w_acc;

      // Operands travel skewed: each stage only carries the bits not yet summed.
      if (s == 0) begin : g_in
         assign w_a   = a;
         assign w_b   = w_b_eff;
         assign w_cin = w_c0;
         assign w_v   = w_accept;
         assign w_acc = w_gsum;
      end else begin : g_fwd
         assign w_a   = g_stg[s-1].g_mid.r_a;
         assign w_b   = g_stg[s-1].g_mid.r_b;
         assign w_cin = g_stg[s-1].g_mid.r_c;
         assign w_v   = g_stg[s-1].g_mid.r_v;
         assign w_acc = {w_gsum, g_stg[s-1].g_mid.r_sum};
      end

      cla_group #(.GROUP(GROUP)) u_grp (
         .a     (w_a[GROUP-1:0]),
         .b_eff (w_b[GROUP-1:0]),
         .cin   (w_cin),
         .sum   (w_gsum),
         .cout  (w_gcout)
      );

      if (s < STAGES - 1) begin : g_mid
         logic [REM-GROUP-1:0] r_a;
         logic [REM-GROUP-1:0] r_b;
         logic [LO+GROUP-1:0]  r_sum;
         logic                 r_c;
         logic                 r_v;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_v   <= 1'b0;
               r_c   <= 1'b0;
               r_a   <= '0;
               r_b   <= '0;
               r_sum <= '0;
            end else if (!w_stall) begin
               r_v   <= w_v;
               r_c   <= w_gcout;
               r_a   <= w_a[REM-1:GROUP];
               r_b   <= w_b[REM-1:GROUP];
               r_sum <= w_acc;
            end
         end
      end else begin : g_last
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_out_v <= 1'b0;
               r_sum   <= '0;
               r_cout  <= 1'b0;
               r_ovf   <= 1'b0;
               r_zero  <= 1'b0;
            end else if (!w_stall) begin
               r_out_v <= w_v;
               r_sum   <= w_acc;
               r_cout  <= w_gcout;
               r_ovf   <= (w_a[GROUP-1] == w_b[GROUP-1]) && (w_gsum[GROUP-1] != w_a[GROUP-1]);
               r_zero  <= ~|w_acc;
            end
         end
      end
   end

   assign out_valid = r_out_v;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
   import pipelined_cla_addsub_pkg::*;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic [1:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   n_checks = 0;
   int   n_errors = 0;
   res_t exp_q[$];

   pipelined_cla_addsub #(.WIDTH(W), .GROUP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain integer arithmetic: unsigned for carry/borrow, signed for overflow.
   function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic [1:0] fop, input logic fcin);
      res_t r;
      int   ua, ub, sa, sb, c, ru, rs;
      ua = int'(fa);
      ub = int'(fb);
      sa = int'($signed(fa));
      sb = int'($signed(fb));
      c  = 0;
      if (fop == OP_ADD || fop == OP_ADC) begin
         if (fop == OP_ADC) c = int'(fcin);
         ru     = ua + ub + c;
         rs     = sa + sb + c;
         r.cout = (ru > 65535);
      end else begin
         if (fop == OP_SBB) c = int'(fcin);
         ru     = ua - ub - c;
         rs     = sa - sb - c;
         r.cout = (ru >= 0);
      end
      r.sum  = ru[W-1:0];
      r.ovf  = (rs > 32767) || (rs < -32768);
      r.zero = (r.sum == 0);
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready_rule", in_ready, ena && !(out_valid && !out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", out_valid, 0);
            end else begin
               chk("result_vs_model", {sum, cout, ovf, zero}, exp_q[0]);
               if (out_ready && ena) void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, op, cin));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic directed(input string name, input logic [W-1:0] da, input logic [W-1:0] db,
                           input logic [1:0] dop, input logic dcin, input logic [W-1:0] es,
                           input logic ec, input logic eo, input logic ez);
      int lat;
      in_valid = 1'b1;
      a = da;
      b = db;
      op = dop;
      cin = dcin;
      step();
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      op = OP_SUB;
      cin = ~dcin;
      lat = 0;
      while (!out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk({name, "_latency"}, lat, 3);
      chk({name, "_sum"}, sum, es);
      chk({name, "_cout"}, cout, ec);
      chk({name, "_ovf"}, ovf, eo);
      chk({name, "_zero"}, zero, ez);
      step();
      chk({name, "_one_cycle"}, out_valid, 0);
   endtask

   task automatic stream6(input bit use_ena);
      fork
         begin
            bit acc;
            int g;
            for (int i = 0; i < 6; i++) begin
               in_valid = 1'b1;
               a = W'($urandom);
               b = W'($urandom);
               op = 2'($urandom_range(0, 3));
               cin = 1'($urandom_range(0, 1));
               g = 0;
               do begin
                  @(negedge clk);
                  acc = in_ready;
                  step();
                  g++;
               end while (!acc && g < 20);
               if (!acc) chk("stream_accept_timeout", 0, 1);
            end
            in_valid = 1'b0;
         end
         begin
            int w;
            w = 0;
            while (!out_valid && w < 20) begin
               step();
               w++;
            end
            chk("stream_first_result", out_valid, 1);
            if (use_ena) ena = 1'b0;
            else out_ready = 1'b0;
            repeat (use_ena ? 2 : 3) begin
               @(negedge clk);
               chk(use_ena ? "ena_stall_in_ready" : "bp_stall_in_ready", in_ready, 0);
               step();
            end
            ena = 1'b1;
            out_ready = 1'b1;
         end
      join
      repeat (8) step();
      chk("stream_drained", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      ena = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = '0;
      b = '0;
      cin = 1'b0;
      op = OP_ADD;

      chk("model_add", model(16'h1234, 16'h0FCD, OP_ADD, 1'b0), {16'h2201, 1'b0, 1'b0, 1'b0});
      chk("model_ovf", model(16'h7FFF, 16'h0001, OP_ADD, 1'b0), {16'h8000, 1'b0, 1'b1, 1'b0});
      chk("model_adc", model(16'hFFFF, 16'h0000, OP_ADC, 1'b1), {16'h0000, 1'b1, 1'b0, 1'b1});
      chk("model_sub", model(16'h0005, 16'h0007, OP_SUB, 1'b0), {16'hFFFE, 1'b0, 1'b0, 1'b0});
      chk("model_sbb", model(16'h0000, 16'h0000, OP_SBB, 1'b1), {16'hFFFF, 1'b0, 1'b0, 1'b0});

      repeat (3) step();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_outputs", {sum, cout, ovf, zero}, 0);
      chk("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;
      step();

      directed("add", 16'h1234, 16'h0FCD, OP_ADD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
      directed("add_ovf", 16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      directed("adc", 16'hFFFF, 16'h0000, OP_ADC, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      directed("sub", 16'h0005, 16'h0007, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      directed("sbb", 16'h0000, 16'h0000, OP_SBB, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      stream6(1'b0);
      stream6(1'b1);

      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         ena = ($urandom_range(0, 7) != 0);
         case ($urandom_range(0, 4))
            0: a = 16'h7FFF;
            1: a = 16'h8000;
            2: a = 16'hFFFF;
            default: a = W'($urandom);
         endcase
         b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
         op = 2'($urandom_range(0, 3));
         cin = 1'($urandom_range(0, 1));
         step();
      end
      in_valid = 1'b0;
      ena = 1'b1;
      out_ready = 1'b1;
      repeat (8) step();
      chk("random_drained", exp_q.size(), 0);

      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         a = 16'h1111 * W'(i + 1);
         b = 16'h2222;
         op = OP_ADD;
         cin = 1'b0;
         step();
      end
      in_valid = 1'b0;
      chk("pre_reset_valid", out_valid, 1);
      chk("pre_reset_sum", sum, 16'h3333);
      #1;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      chk("async_reset_valid", out_valid, 0);
      chk("async_reset_outputs", {sum, cout, ovf, zero}, 0);
      chk("async_reset_in_ready", in_ready, 1);
      out_ready = 1'b1;
      step();
      step();
      rst_n = 1'b1;
      repeat (10) step();
      chk("no_stale_after_reset", out_valid, 0);
      directed("post_reset", 16'h0001, 16'h0001, OP_ADD, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
